// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: skid-stage occupancy encoding.
package pipe_pkg;

    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StHalf  = 2'b01,
        StFull  = 2'b10
    } skid_state_e;

    function automatic logic state_has_data(input skid_state_e st);
        return st != StEmpty;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, cleared only by reset.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with registered in_ready and 2-entry skid buffer.
// Optional stall counter enabled by PIPE_STAGE_SKID_PERF_EN.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned     WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
`ifdef PIPE_STAGE_SKID_PERF_EN
    ,
    parameter int unsigned     CNT_W     = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef PIPE_STAGE_SKID_PERF_EN
    output logic [CNT_W-1:0] stall_cnt,
`endif
    output logic [WIDTH-1:0] out_data
);

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             in_fire, out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            StEmpty: begin
                if (in_fire) begin
                    state_d = StHalf;
                    main_d  = in_data;
                end
            end
            StHalf: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    state_d = StFull;
                    skid_d  = in_data;
                end else if (out_fire) begin
                    // main keeps its last word so out_data is not cleared
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (out_fire) begin
                    state_d = StHalf;
                    main_d  = skid_q;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // Flags are registered from the next state so neither depends on out_ready combinationally.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q     <= StEmpty;
            main_q      <= RESET_VAL;
            skid_q      <= RESET_VAL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != StFull);
            out_valid_q <= state_has_data(state_d);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

`ifdef PIPE_STAGE_SKID_PERF_EN
    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (out_valid_q & ~out_ready),
        .count(stall_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomized bench for pipe_stage_skid against a 2-deep queue model.
module tb_pipe_stage_skid;

    localparam int unsigned     W       = 8;
    localparam logic [W-1:0]    RST     = 8'h5A;
    localparam int              CNT_MAX = 15;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
`ifdef PIPE_STAGE_SKID_PERF_EN
    logic [3:0]   stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] mq[$];
    logic [W-1:0] m_last = RST;
    int           m_cnt  = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .WIDTH    (W),
        .RESET_VAL(RST)
`ifdef PIPE_STAGE_SKID_PERF_EN
        ,
        .CNT_W    (4)
`endif
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef PIPE_STAGE_SKID_PERF_EN
        .stall_cnt(stall_cnt),
`endif
        .out_data (out_data)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_eq("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        check_eq("in_ready", 32'(in_ready), 32'(mq.size() < 2));
        check_eq("out_data", 32'(out_data), 32'((mq.size() > 0) ? mq[0] : m_last));
`ifdef PIPE_STAGE_SKID_PERF_EN
        check_eq("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
`endif
    endtask

    // Called at a negedge: drive, advance one edge, update the model, check.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic ordy,
                         input logic fl, input logic rst);
        bit m_inf, m_outf;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        m_inf  = v && (mq.size() < 2);
        m_outf = (mq.size() > 0) && ordy;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_last = RST;
            m_cnt  = 0;
        end else begin
            if ((mq.size() > 0) && !ordy && (m_cnt < CNT_MAX)) m_cnt++;
            if (fl) begin
                mq.delete();
                m_last = RST;
            end else begin
                if (m_outf) m_last = mq.pop_front();
                if (m_inf) mq.push_back(d);
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        logic         cur_v;
        logic [W-1:0] cur_d;

        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check_eq("reset_out_data", 32'(out_data), 32'(RST));

        // Back-to-back stream
        cycle(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
        check_eq("lat_11", 32'(out_data), 32'h11);
        cycle(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
        check_eq("lat_22", 32'(out_data), 32'h22);
        cycle(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        check_eq("lat_33", 32'(out_data), 32'h33);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_eq("retain_33", 32'(out_data), 32'h33);

        // Stall into FULL, then drain
        cycle(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
        check_eq("full_in_ready", 32'(in_ready), 32'h0);
        cycle(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
        check_eq("held_A1", 32'(out_data), 32'hA1);
        cycle(1'b1, 8'hA3, 1'b1, 1'b0, 1'b0);
        check_eq("drain_A2", 32'(out_data), 32'hA2);
        cycle(1'b1, 8'hA3, 1'b1, 1'b0, 1'b0);
        check_eq("drain_A3", 32'(out_data), 32'hA3);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Flush from FULL with a word offered
        cycle(1'b1, 8'hB1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hB3, 1'b0, 1'b1, 1'b0);
        check_eq("flush_valid", 32'(out_valid), 32'h0);
        check_eq("flush_ready", 32'(in_ready), 32'h1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Reset in HALF with a simultaneous accept
        cycle(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hC2, 1'b0, 1'b0, 1'b1);
        check_eq("rst_half_data", 32'(out_data), 32'(RST));
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Long stall: counter saturates; flush must not clear it
        cycle(1'b1, 8'hD1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_SKID_PERF_EN
        check_eq("stall_sat", 32'(stall_cnt), 32'd15);
`endif
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
`ifdef PIPE_STAGE_SKID_PERF_EN
        check_eq("stall_after_flush", 32'(stall_cnt), 32'd15);
`endif
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // Random traffic, upstream holds data while blocked or withdraws
        cur_v = 1'b0;
        cur_d = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!(cur_v && (mq.size() == 2) && ($urandom_range(3) != 0))) begin
                cur_v = ($urandom_range(3) != 0);
                cur_d = W'($urandom);
            end
            cycle(cur_v, cur_d, ($urandom_range(2) != 0), ($urandom_range(31) == 0),
                  ($urandom_range(199) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
